// File: rtl/cdb_pkg.sv
// cdb_pkg: shared entry layout helpers and clog2 for the common data bus.
// Entry layout, LSB to MSB: ScbID, ActiveMask, Instr, Data, Dst, WarpID, RegWrite.
package cdb_pkg;

   typedef enum logic [2:0] {
      F_SCB,
      F_MASK,
      F_INSTR,
      F_DATA,
      F_DST,
      F_WARP,
      F_RW
   } field_e;

   function automatic int clog2(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return r;
   endfunction

   // Bit offset of a field: the sum of the widths of every field packed below it.
   function automatic int field_off(input field_e f, input int warp_w, dst_w, data_w,
                                    instr_w, mask_w, scb_w);
      int o;
      o = 0;
      if (f > F_SCB)   o += scb_w;
      if (f > F_MASK)  o += mask_w;
      if (f > F_INSTR) o += instr_w;
      if (f > F_DATA)  o += data_w;
      if (f > F_DST)   o += dst_w;
      if (f > F_WARP)  o += warp_w;
      return o;
   endfunction

   function automatic int entry_w(input int warp_w, dst_w, data_w, instr_w, mask_w, scb_w);
      return field_off(F_RW, warp_w, dst_w, data_w, instr_w, mask_w, scb_w) + 1;
   endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: per-source writeback FIFO with count-derived full/empty flags.
// Ports: clk, rst (async, active-high), push/din write side, pop/dout read side
// (dout shows the head), full and empty status.
module cdb_src_fifo
   import cdb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [AW:0]      count;

   assign full  = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign dout  = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common data bus from NUM_SRC execution units to RAU and scoreboard.
// Ports: clk, rst (async, active-high); per-source packed valid/ready writeback beats
// (*_SRC_CDB, Ready_CDB_SRC); Stall_RAU_CDB backpressure; registered RAU write port
// (*_CDB_RAU); scoreboard clear port (Clear_*_CDB_Scb); Grant_CDB_Dbg one-hot grant.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int FIFO_DEPTH = 2,
   parameter int DATA_W     = 256,
   parameter int WARP_W     = 3,
   parameter int DST_W      = 5,
   parameter int ADDR_W     = 3,
   parameter int INSTR_W    = 32,
   parameter int MASK_W     = 8,
   parameter int SCB_W      = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_SRC-1:0]          Valid_SRC_CDB,
   output logic [NUM_SRC-1:0]          Ready_CDB_SRC,
   input  logic [NUM_SRC-1:0]          RegWrite_SRC_CDB,
   input  logic [NUM_SRC*WARP_W-1:0]   WarpID_SRC_CDB,
   input  logic [NUM_SRC*DST_W-1:0]    Dst_SRC_CDB,
   input  logic [NUM_SRC*DATA_W-1:0]   Data_SRC_CDB,
   input  logic [NUM_SRC*INSTR_W-1:0]  Instr_SRC_CDB,
   input  logic [NUM_SRC*MASK_W-1:0]   ActiveMask_SRC_CDB,
   input  logic [NUM_SRC*SCB_W-1:0]    ScbID_SRC_CDB,
   input  logic                        Stall_RAU_CDB,
   output logic                        Valid_CDB_RAU,
   output logic                        RegWrite_CDB_RAU,
   output logic [WARP_W-1:0]           HWWarp_CDB_RAU,
   output logic [ADDR_W-1:0]           WriteAddr_CDB_RAU,
   output logic [DATA_W-1:0]           Data_CDB_RAU,
   output logic [INSTR_W-1:0]          Instr_CDB_RAU,
   output logic [MASK_W-1:0]           ActiveMask_CDB_RAU,
   output logic                        Clear_Valid_CDB_Scb,
   output logic [WARP_W-1:0]           Clear_WarpID_CDB_Scb,
   output logic [SCB_W-1:0]            Clear_ScbID_CDB_Scb,
   output logic [NUM_SRC-1:0]          Grant_CDB_Dbg
);

   localparam int PW      = clog2(NUM_SRC);
   localparam int O_MASK  = field_off(F_MASK,  WARP_W, DST_W, DATA_W, INSTR_W, MASK_W, SCB_W);
   localparam int O_INSTR = field_off(F_INSTR, WARP_W, DST_W, DATA_W, INSTR_W, MASK_W, SCB_W);
   localparam int O_DATA  = field_off(F_DATA,  WARP_W, DST_W, DATA_W, INSTR_W, MASK_W, SCB_W);
   localparam int O_DST   = field_off(F_DST,   WARP_W, DST_W, DATA_W, INSTR_W, MASK_W, SCB_W);
   localparam int O_WARP  = field_off(F_WARP,  WARP_W, DST_W, DATA_W, INSTR_W, MASK_W, SCB_W);
   localparam int O_RW    = field_off(F_RW,    WARP_W, DST_W, DATA_W, INSTR_W, MASK_W, SCB_W);
   localparam int EW      = entry_w(WARP_W, DST_W, DATA_W, INSTR_W, MASK_W, SCB_W);

   logic [EW-1:0]      din  [NUM_SRC];
   logic [EW-1:0]      head [NUM_SRC];
   logic [NUM_SRC-1:0] full, empty, push, grant;
   logic [PW-1:0]      rr_ptr, gidx;
   logic               rdy_en, any_grant, free, valid_q;
   logic [EW-1:0]      out_q;
   logic               unused_dst_hi;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign din[i] = {RegWrite_SRC_CDB[i],
                       WarpID_SRC_CDB[i*WARP_W +: WARP_W],
                       Dst_SRC_CDB[i*DST_W +: DST_W],
                       Data_SRC_CDB[i*DATA_W +: DATA_W],
                       Instr_SRC_CDB[i*INSTR_W +: INSTR_W],
                       ActiveMask_SRC_CDB[i*MASK_W +: MASK_W],
                       ScbID_SRC_CDB[i*SCB_W +: SCB_W]};
      assign push[i] = Valid_SRC_CDB[i] & Ready_CDB_SRC[i];
      cdb_src_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[i]),
         .din   (din[i]),
         .pop   (grant[i]),
         .dout  (head[i]),
         .full  (full[i]),
         .empty (empty[i])
      );
   end

   // rdy_en keeps Ready low during reset and until the first edge after it.
   assign Ready_CDB_SRC = {NUM_SRC{rdy_en}} & ~full;
   assign free          = ~valid_q | ~Stall_RAU_CDB;

   // First non-empty source at or after rr_ptr, searching modulo NUM_SRC.
   always_comb begin
      grant     = '0;
      gidx      = rr_ptr;
      any_grant = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (free && !any_grant && !empty[(int'(rr_ptr) + k) % NUM_SRC]) begin
            any_grant = 1'b1;
            gidx      = PW'((int'(rr_ptr) + k) % NUM_SRC);
            grant[(int'(rr_ptr) + k) % NUM_SRC] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_en  <= 1'b0;
         rr_ptr  <= '0;
         valid_q <= 1'b0;
         out_q   <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (any_grant) begin
            rr_ptr <= (gidx == PW'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;
            out_q  <= head[gidx];
         end
         if (free) valid_q <= any_grant;
      end
   end

   // Only the low ADDR_W bits of Dst address the RAU; the rest is carried but not driven out.
   assign unused_dst_hi = ^out_q[O_DST+ADDR_W +: DST_W-ADDR_W];

   assign Valid_CDB_RAU        = valid_q;
   assign RegWrite_CDB_RAU     = valid_q & out_q[O_RW];
   assign HWWarp_CDB_RAU       = out_q[O_WARP +: WARP_W];
   assign WriteAddr_CDB_RAU    = out_q[O_DST +: ADDR_W];
   assign Data_CDB_RAU         = out_q[O_DATA +: DATA_W];
   assign Instr_CDB_RAU        = out_q[O_INSTR +: INSTR_W];
   assign ActiveMask_CDB_RAU   = out_q[O_MASK +: MASK_W];
   assign Clear_Valid_CDB_Scb  = valid_q & ~Stall_RAU_CDB;
   assign Clear_WarpID_CDB_Scb = out_q[O_WARP +: WARP_W];
   assign Clear_ScbID_CDB_Scb  = out_q[0 +: SCB_W];
   assign Grant_CDB_Dbg        = grant;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed tables and sequences on a 2-source bus, randomized model check on a 3-source bus.
module tb_cdb_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   typedef struct packed {
      logic        rw;
      logic [2:0]  warp;
      logic [4:0]  dst;
      logic [31:0] data;
      logic [31:0] instr;
      logic [7:0]  mask;
      logic [1:0]  scb;
   } beat_t;

   typedef struct {
      int         src;
      logic       rw;
      logic [2:0] warp;
      logic [4:0] dst;
      logic [1:0] scb;
      logic [2:0] e_addr;
      logic       e_rw;
   } vec_t;

   logic [1:0]   v2, rw2, rdy2, gnt2;
   logic [5:0]   warp2;
   logic [9:0]   dst2;
   logic [511:0] data2;
   logic [63:0]  instr2;
   logic [15:0]  mask2;
   logic [3:0]   scb2;
   logic         stall2, ov2, orw2, cv2;
   logic [2:0]   owarp2, oaddr2, cwarp2;
   logic [255:0] odata2;
   logic [31:0]  oinstr2;
   logic [7:0]   omask2;
   logic [1:0]   cscb2;

   logic [2:0]   v3, rw3, rdy3, gnt3;
   logic [8:0]   warp3;
   logic [14:0]  dst3;
   logic [95:0]  data3;
   logic [95:0]  instr3;
   logic [23:0]  mask3;
   logic [5:0]   scb3;
   logic         stall3, ov3, orw3, cv3;
   logic [2:0]   owarp3, oaddr3, cwarp3;
   logic [31:0]  odata3;
   logic [31:0]  oinstr3;
   logic [7:0]   omask3;
   logic [1:0]   cscb3;

   cdb_arbiter dut2 (
      .clk(clk), .rst(rst),
      .Valid_SRC_CDB(v2), .Ready_CDB_SRC(rdy2), .RegWrite_SRC_CDB(rw2),
      .WarpID_SRC_CDB(warp2), .Dst_SRC_CDB(dst2), .Data_SRC_CDB(data2),
      .Instr_SRC_CDB(instr2), .ActiveMask_SRC_CDB(mask2), .ScbID_SRC_CDB(scb2),
      .Stall_RAU_CDB(stall2), .Valid_CDB_RAU(ov2), .RegWrite_CDB_RAU(orw2),
      .HWWarp_CDB_RAU(owarp2), .WriteAddr_CDB_RAU(oaddr2), .Data_CDB_RAU(odata2),
      .Instr_CDB_RAU(oinstr2), .ActiveMask_CDB_RAU(omask2), .Clear_Valid_CDB_Scb(cv2),
      .Clear_WarpID_CDB_Scb(cwarp2), .Clear_ScbID_CDB_Scb(cscb2), .Grant_CDB_Dbg(gnt2)
   );

   cdb_arbiter #(.NUM_SRC(3), .DATA_W(32)) dut3 (
      .clk(clk), .rst(rst),
      .Valid_SRC_CDB(v3), .Ready_CDB_SRC(rdy3), .RegWrite_SRC_CDB(rw3),
      .WarpID_SRC_CDB(warp3), .Dst_SRC_CDB(dst3), .Data_SRC_CDB(data3),
      .Instr_SRC_CDB(instr3), .ActiveMask_SRC_CDB(mask3), .ScbID_SRC_CDB(scb3),
      .Stall_RAU_CDB(stall3), .Valid_CDB_RAU(ov3), .RegWrite_CDB_RAU(orw3),
      .HWWarp_CDB_RAU(owarp3), .WriteAddr_CDB_RAU(oaddr3), .Data_CDB_RAU(odata3),
      .Instr_CDB_RAU(oinstr3), .ActiveMask_CDB_RAU(omask3), .Clear_Valid_CDB_Scb(cv3),
      .Clear_WarpID_CDB_Scb(cwarp3), .Clear_ScbID_CDB_Scb(cscb3), .Grant_CDB_Dbg(gnt3)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic beat_t rnd_beat();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[$bits(beat_t)-1:0];
   endfunction

   function automatic int oh2i(input logic [2:0] g);
      return (g == 3'b001) ? 0 : (g == 3'b010) ? 1 : (g == 3'b100) ? 2 : -1;
   endfunction

   task automatic put2(input int s, input beat_t b, input logic [255:0] dat);
      v2[s] = 1'b1;
      rw2[s] = b.rw;
      warp2[s*3 +: 3] = b.warp;
      dst2[s*5 +: 5] = b.dst;
      data2[s*256 +: 256] = dat;
      instr2[s*32 +: 32] = b.instr;
      mask2[s*8 +: 8] = b.mask;
      scb2[s*2 +: 2] = b.scb;
   endtask

   task automatic put3(input int s, input beat_t b);
      rw3[s] = b.rw;
      warp3[s*3 +: 3] = b.warp;
      dst3[s*5 +: 5] = b.dst;
      data3[s*32 +: 32] = b.data;
      instr3[s*32 +: 32] = b.instr;
      mask3[s*8 +: 8] = b.mask;
      scb3[s*2 +: 2] = b.scb;
   endtask

   initial begin
      vec_t         tbl [4];
      beat_t        b;
      logic [255:0] dat;
      logic [31:0]  got [$];
      int           ia, ib, first, last, wraps, g;
      logic         dropped, stale, fr, fair;
      beat_t        q [3][$];
      beat_t        nb [3];
      beat_t        oe;
      logic         ov_m;
      logic [2:0]   er;
      int           rr;
      int           gseq [$];

      v2 = '0; rw2 = '0; warp2 = '0; dst2 = '0; data2 = '0; instr2 = '0; mask2 = '0; scb2 = '0; stall2 = 1'b0;
      v3 = '0; rw3 = '0; warp3 = '0; dst3 = '0; data3 = '0; instr3 = '0; mask3 = '0; scb3 = '0; stall3 = 1'b0;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready2", rdy2, 0);
      check("rst_ready3", rdy3, 0);
      check("rst_valid", ov2, 0);
      check("rst_outs", {orw2, owarp2, oaddr2, odata2[31:0], oinstr2, omask2, cv2, cwarp2, cscb2, gnt2}, 0);
      rst = 1'b0;
      tick();
      check("ready_after_rst2", rdy2, 2'b11);
      check("ready_after_rst3", rdy3, 3'b111);

      // Single beats; sources alternate so the pointer ends back at ALU.
      tbl[0] = '{0, 1'b1, 3'd5, 5'h0B, 2'd2, 3'd3, 1'b1};
      tbl[1] = '{1, 1'b0, 3'd6, 5'h1C, 2'd1, 3'd4, 1'b0};
      tbl[2] = '{0, 1'b0, 3'd0, 5'h10, 2'd0, 3'd0, 1'b0};
      tbl[3] = '{1, 1'b1, 3'd2, 5'h07, 2'd3, 3'd7, 1'b1};
      for (int i = 0; i < 4; i++) begin
         b = rnd_beat();
         b.rw = tbl[i].rw; b.warp = tbl[i].warp; b.dst = tbl[i].dst; b.scb = tbl[i].scb;
         for (int j = 0; j < 8; j++) dat[j*32 +: 32] = $urandom;
         put2(tbl[i].src, b, dat);
         tick();
         v2 = '0;
         #1;
         check("tbl_grant", gnt2, 1 << tbl[i].src);
         check("tbl_no_early_valid", ov2, 0);
         tick();
         #1;
         check("tbl_valid", ov2, 1);
         check("tbl_regwrite", orw2, tbl[i].e_rw);
         check("tbl_waddr", oaddr2, tbl[i].e_addr);
         check("tbl_warp", owarp2, tbl[i].warp);
         check("tbl_clr_warp", cwarp2, tbl[i].warp);
         check("tbl_clr_scb", cscb2, tbl[i].scb);
         check("tbl_clr_valid", cv2, 1);
         check("tbl_payload", {odata2, oinstr2, omask2}, {dat, b.instr, b.mask});
         tick();
         #1;
         check("tbl_one_cycle", {ov2, cv2}, 0);
      end

      // Back-to-back burst of 4 beats per source.
      ia = 0; ib = 0; first = -1; last = -1; dropped = 1'b0;
      for (int c = 0; c < 30; c++) begin
         tick();
         v2 = '0;
         if (ia < 4) begin b = rnd_beat(); b.instr = 32'hA000_0000 + ia; put2(0, b, '0); end
         if (ib < 4) begin b = rnd_beat(); b.instr = 32'hB000_0000 + ib; put2(1, b, '0); end
         #1;
         if (rdy2 != 2'b11) dropped = 1'b1;
         if (ov2) begin
            got.push_back(oinstr2);
            if (first < 0) first = c;
            last = c;
         end
         if (v2[0] && rdy2[0]) ia++;
         if (v2[1] && rdy2[1]) ib++;
      end
      check("burst_count", got.size(), 8);
      for (int k = 0; k < 8; k++)
         check("burst_order", (k < got.size()) ? got[k] : 32'h0,
               ((k % 2) == 0 ? 32'hA000_0000 : 32'hB000_0000) + k / 2);
      check("burst_rate", last - first, 7);
      check("burst_ready_drop", dropped, 1);

      // Stall held 3 cycles with beats queued behind the output.
      tick();
      v2 = '0;
      b = rnd_beat(); b.warp = 3'd1; b.instr = 32'hC0; put2(0, b, '0);
      b = rnd_beat(); b.instr = 32'hC1; put2(1, b, '0);
      tick();
      v2 = '0;
      b = rnd_beat(); b.instr = 32'hC2; put2(0, b, '0);
      #1;
      check("stall_pre_grant", gnt2, 2'b01);
      tick();
      v2 = '0;
      stall2 = 1'b1;
      for (int s = 0; s < 3; s++) begin
         #1;
         check("stall_hold", {ov2, oinstr2, owarp2}, {1'b1, 32'hC0, 3'd1});
         check("stall_no_clear", cv2, 0);
         check("stall_no_grant", gnt2, 0);
         tick();
      end
      stall2 = 1'b0;
      #1;
      check("release_clear", cv2, 1);
      check("release_rr", gnt2, 2'b10);
      tick();
      #1;
      check("release_next", oinstr2, 32'hC1);
      check("release_next_grant", gnt2, 2'b01);
      tick();
      #1;
      check("release_last", oinstr2, 32'hC2);
      tick();
      #1;
      check("release_drain", ov2, 0);

      // Asynchronous reset with queued and in-flight beats.
      b = rnd_beat();
      put2(0, b, '1); put2(1, b, '1);
      tick();
      tick();
      v2 = '0;
      stall2 = 1'b1;
      #1;
      check("pre_rst_valid", ov2, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", {ov2, cv2, orw2}, 0);
      check("async_rst_fields", {owarp2, oaddr2, odata2, oinstr2, omask2, cwarp2, cscb2}, 0);
      check("async_rst_ready", rdy2, 0);
      check("async_rst_grant", gnt2, 0);
      stall2 = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      stale = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         stale |= ov2 | cv2 | (|gnt2);
      end
      check("no_stale_beat", stale, 0);
      check("ready_after_async", rdy2, 2'b11);

      // Randomized traffic on the 3-source bus against a queue model, then a fairness phase.
      oe = '0; ov_m = 1'b0; rr = 0; wraps = 0;
      for (int c = 0; c < 1600; c++) begin
         fair = c >= 1500;
         tick();
         for (int i = 0; i < 3; i++) begin
            nb[i] = rnd_beat();
            v3[i] = fair ? 1'b1 : ($urandom_range(0, 2) != 0);
            put3(i, nb[i]);
         end
         stall3 = fair ? 1'b0 : ($urandom_range(0, 3) == 0);
         #1;
         for (int i = 0; i < 3; i++) er[i] = q[i].size() < 2;
         fr = !ov_m || !stall3;
         g = -1;
         if (fr)
            for (int k = 0; k < 3; k++)
               if (g < 0 && q[(rr + k) % 3].size() > 0) g = (rr + k) % 3;
         check("rnd_ready", rdy3, er);
         check("rnd_grant", gnt3, (g < 0) ? 0 : (1 << g));
         check("rnd_valid", ov3, ov_m);
         check("rnd_clear", cv3, ov_m && !stall3);
         check("rnd_fields", {orw3, owarp3, oaddr3, odata3, oinstr3, omask3, cscb3, cwarp3},
               {ov_m & oe.rw, oe.warp, oe.dst[2:0], oe.data, oe.instr, oe.mask, oe.scb, oe.warp});
         if (fair && c >= 1505) gseq.push_back(oh2i(gnt3));
         if (g >= 0) begin
            oe = q[g].pop_front();
            rr = (g + 1) % 3;
         end
         if (fr) ov_m = g >= 0;
         for (int i = 0; i < 3; i++)
            if (v3[i] && er[i]) q[i].push_back(nb[i]);
      end
      tick();
      v3 = '0;
      for (int k = 0; k + 2 < gseq.size(); k++) begin
         check("fair_window", (gseq[k] < 0 || gseq[k+1] < 0 || gseq[k+2] < 0) ? 0 :
               ((1 << gseq[k]) | (1 << gseq[k+1]) | (1 << gseq[k+2])), 7);
         if (gseq[k] == 2 && gseq[k+1] == 0) wraps++;
      end
      check("ptr_wrap_seen", wraps > 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
